// File: rtl/ps_shift_engine.sv
// Parallel-in/serial-out shift engine: loads a word, then shifts it out for a
// programmable count with selectable direction and serial-in or rotate fill.
module ps_shift_engine #(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH+1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  input  logic [CW-1:0]    len,
  input  logic             dir,
  input  logic             rot,
  input  logic             en,
  input  logic             sin,
  output logic             sout,
  output logic [WIDTH-1:0] qout,
  output logic             busy,
  output logic             done
);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [CW-1:0]    cnt_q, cnt_ld;
  logic             dir_q, rot_q, busy_q, done_q;
  logic             fill;

  assign sout = dir_q ? sr_q[0] : sr_q[WIDTH-1];
  assign qout = sr_q;
  assign busy = busy_q;
  assign done = done_q;

  always_comb begin
    fill   = rot_q ? sout : sin;
    sr_d   = dir_q ? {fill, sr_q[WIDTH-1:1]} : {sr_q[WIDTH-2:0], fill};
    // A zero or oversized length means a full-word transfer.
    cnt_ld = (len == '0 || len > CW'(WIDTH)) ? CW'(WIDTH) : len;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      rot_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            sr_q    <= din;
            dir_q   <= dir;
            rot_q   <= rot;
            cnt_q   <= cnt_ld;
            busy_q  <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          if (en) begin
            sr_q  <= sr_d;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps_shift_engine.sv
// Scoreboard bench for ps_shift_engine: stimulus queues expected serial bits and
// final words; a negedge monitor pops and compares as the DUT produces them.
module tb_ps_shift_engine;
  localparam int W  = 8;
  localparam int CW = $clog2(W+1);

  logic          clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic          dir = 1'b0, rot = 1'b0, en = 1'b1, sin = 1'b0;
  logic [W-1:0]  din = '0;
  logic [CW-1:0] len = '0;
  logic          sout, busy, done;
  logic [W-1:0]  qout;

  int n_tests = 0, n_fail = 0, cyc = 0, t0 = 0, done_cnt = 0;
  logic         bq[$];
  logic [W-1:0] qq[$];

  ps_shift_engine #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .din(din), .len(len), .dir(dir),
    .rot(rot), .en(en), .sin(sin), .sout(sout), .qout(qout), .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: a bit is consumed on every busy cycle with en high; done retires a word.
  always @(negedge clk) begin
    if (!rst) begin
      if (busy && en) begin
        if (bq.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL sout_unexpected: got %0b expected none", sout);
        end else chk("sout", sout, bq.pop_front());
      end
      if (done) begin
        done_cnt++;
        if (qq.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL done_unexpected: got qout %0h expected no done", qout);
        end else chk("qout_final", qout, qq.pop_front());
      end
    end
  end

  task automatic issue(input logic [W-1:0] d, input logic [CW-1:0] l, input logic dr,
                       input logic rt, input logic s, input logic [W-1:0] bits,
                       input int n, input logic [W-1:0] fq, input bit push_q);
    din = d; len = l; dir = dr; rot = rt; sin = s; start = 1'b1;
    for (int i = n-1; i >= 0; i--) bq.push_back(bits[i]);
    if (push_q) qq.push_back(fq);
    @(posedge clk); #1;
    t0 = cyc;
    start = 1'b0;
  endtask

  task automatic wait_done(input int max, output int lat, output int nbusy);
    bit got = 0;
    lat = -1; nbusy = 0;
    for (int i = 0; i < max && !got; i++) begin
      @(negedge clk);
      if (done) begin lat = cyc - t0; got = 1; end
      else if (busy) nbusy++;
    end
    if (!got) begin
      n_tests++; n_fail++;
      $display("FAIL done_timeout: got no done expected within %0d cycles", max);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, nb, dc;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_qout", qout, 0); chk("rst_sout", sout, 0);
    chk("rst_busy", busy, 0); chk("rst_done", done, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Full word, MSB first, sin=0 fill.
    issue(8'hBB, 0, 0, 0, 0, 8'hBB, 8, 8'h00, 1);
    wait_done(40, lat, nb);
    chk("t1_lat", lat, 8); chk("t1_busy_cycles", nb, 8);
    @(negedge clk) chk("t1_done_pulse", done, 0);

    // LSB first, rotate.
    @(posedge clk); #1;
    issue(8'hBB, 8, 1, 1, 0, 8'b11011101, 8, 8'hBB, 1);
    wait_done(40, lat, nb);
    chk("t2_lat", lat, 8);

    // Short transfer with sin=1, then oversized length.
    @(posedge clk); #1;
    issue(8'hA5, 3, 0, 0, 1, 8'b101, 3, 8'h2F, 1);
    wait_done(40, lat, nb);
    chk("t3_lat", lat, 3); chk("t3_busy_cycles", nb, 3);
    @(posedge clk); #1;
    issue(8'hA5, 12, 0, 0, 1, 8'hA5, 8, 8'hFF, 1);
    wait_done(40, lat, nb);
    chk("t3_len12_lat", lat, 8);

    // Stall after two shifts, with a start that must be ignored.
    @(posedge clk); #1;
    issue(8'hF0, 4, 0, 0, 0, 8'b1111, 4, 8'h00, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    en = 1'b0; start = 1'b1; din = 8'h00; len = 1;
    @(negedge clk);
    chk("t4_stall_qout0", qout, 8'hC0); chk("t4_stall_sout0", sout, 1);
    chk("t4_stall_busy", busy, 1);
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("t4_stall_qout1", qout, 8'hC0); chk("t4_stall_sout1", sout, 1);
    @(posedge clk); #1 en = 1'b1;
    wait_done(40, lat, nb);
    chk("t4_lat", lat, 6);

    // Reset after the third shift aborts silently.
    @(posedge clk); #1;
    issue(8'hBB, 0, 0, 0, 0, 8'b101, 3, 8'h00, 0);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1; dc = done_cnt;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("t5_qout", qout, 0); chk("t5_busy", busy, 0);
    chk("t5_done", done, 0); chk("t5_sout", sout, 0);
    repeat (4) @(negedge clk);
    chk("t5_no_done", done_cnt, dc);
    @(posedge clk); #1;
    issue(8'hA5, 3, 0, 0, 1, 8'b101, 3, 8'h2F, 1);
    wait_done(40, lat, nb);
    chk("t5_restart_lat", lat, 3);

    // Back-to-back: start issued in the done cycle.
    @(posedge clk); #1;
    issue(8'h81, 2, 0, 0, 0, 8'b10, 2, 8'h04, 1);
    wait_done(40, lat, nb);
    chk("t6a_lat", lat, 2);
    issue(8'h3C, 0, 0, 0, 0, 8'h3C, 8, 8'h00, 1);
    @(negedge clk);
    chk("t6_no_gap_busy", busy, 1); chk("t6_first_bit", sout, 0);
    wait_done(40, lat, nb);
    chk("t6b_lat", lat, 8);

    repeat (2) @(negedge clk);
    chk("done_count", done_cnt, 8);
    chk("bits_drained", bq.size(), 0);
    chk("words_drained", qq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
